// File: rtl/debouncer_multi.sv
// ---------------------------------------------------------------------------
// debouncer_multi
//
// Debounces NCH asynchronous inputs. Each channel has a two-flop synchroniser
// and a saturating up/down integrator. All channels share one sample
// prescaler. The debounced level changes only when the integrator is already
// saturated and the next sample agrees with it. This gives full-range
// hysteresis against glitches.
//
// Each level change is reported three ways:
//   - the debounced level itself,
//   - one-cycle rise/fall pulses, aligned with the first cycle of the new level,
//   - sticky event flags (write-1-to-clear), ORed under a mask into a
//     registered interrupt.
//
// Ports:
//   clk_i   in   1    clock
//   rst_i   in   1    asynchronous reset, active low
//   in_i    in   NCH  raw asynchronous inputs
//   out_o   out  NCH  debounced levels
//   rise_o  out  NCH  one-cycle pulse when out_o[k] goes 0->1
//   fall_o  out  NCH  one-cycle pulse when out_o[k] goes 1->0
//   evt_o   out  NCH  sticky event flags (edge selected by EDGE_MODE)
//   clr_i   in   NCH  write-1-to-clear for evt_o; a new event in the same cycle wins
//   mask_i  in   NCH  interrupt enable per channel
//   irq_o   out  1    registered OR of (evt_o & mask_i)
// ---------------------------------------------------------------------------
module debouncer_multi #(
    parameter int NCH        = 4,
    parameter int FACTOR_POW = 20,
    parameter int TICK_DIV   = 1,
    parameter bit INIT       = 1'b0,
    parameter int EDGE_MODE  = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [NCH-1:0] in_i,
    output logic [NCH-1:0] out_o,
    output logic [NCH-1:0] rise_o,
    output logic [NCH-1:0] fall_o,
    output logic [NCH-1:0] evt_o,
    input  logic [NCH-1:0] clr_i,
    input  logic [NCH-1:0] mask_i,
    output logic           irq_o
);

    localparam int                    PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [FACTOR_POW-1:0] CNT_MAX    = '1;
    localparam logic [FACTOR_POW-1:0] CNT_INIT   = INIT ? CNT_MAX : '0;
    localparam logic [NCH-1:0]        LEVEL_INIT = {NCH{INIT}};
    localparam logic [NCH-1:0]        RISE_EN    = {NCH{EDGE_MODE != 1}};
    localparam logic [NCH-1:0]        FALL_EN    = {NCH{EDGE_MODE != 0}};

    logic [PW-1:0]                    r_presc;
    logic                             w_tick;
    logic [NCH-1:0]                   r_sync0;
    logic [NCH-1:0]                   r_sync1;
    logic [NCH-1:0][FACTOR_POW-1:0]   r_cnt;
    logic [NCH-1:0][FACTOR_POW-1:0]   w_cntNext;
    logic [NCH-1:0]                   r_out;
    logic [NCH-1:0]                   w_outNext;
    logic [NCH-1:0]                   r_rise;
    logic [NCH-1:0]                   r_fall;
    logic [NCH-1:0]                   w_rise;
    logic [NCH-1:0]                   w_fall;
    logic [NCH-1:0]                   w_evtSet;
    logic [NCH-1:0]                   r_evt;
    logic                             r_irq;

    // Shared prescaler: the tick is asserted in the last cycle of each period.
    // With TICK_DIV=1, PRESC_LAST is 0, so every cycle is a tick.
    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Two-flop synchroniser. It runs every clock, independent of the tick.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sync0 <= LEVEL_INIT;
            r_sync1 <= LEVEL_INIT;
        end else begin
            r_sync0 <= in_i;
            r_sync1 <= r_sync0;
        end
    end

    // Integrator next state.
    // A sample moves the counter toward its saturation rail.
    // A sample that arrives while the counter is already on the matching rail
    // commits the new level. Because of this, the level changes one tick after
    // saturation, not in the same tick.
    always_comb begin
        w_cntNext = r_cnt;
        w_outNext = r_out;
        if (w_tick) begin
            for (int k = 0; k < NCH; k++) begin
                if (r_sync1[k]) begin
                    if (r_cnt[k] != CNT_MAX) begin
                        w_cntNext[k] = r_cnt[k] + 1'b1;
                    end else begin
                        w_outNext[k] = 1'b1;
                    end
                end else begin
                    if (r_cnt[k] != '0) begin
                        w_cntNext[k] = r_cnt[k] - 1'b1;
                    end else begin
                        w_outNext[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Edge pulses come from the next level, not the current one.
    // Registering them makes them line up with the new out_o value.
    assign w_rise   = w_outNext & ~r_out;
    assign w_fall   = ~w_outNext & r_out;
    assign w_evtSet = (w_rise & RISE_EN) | (w_fall & FALL_EN);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt  <= {NCH{CNT_INIT}};
            r_out  <= LEVEL_INIT;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_cnt  <= w_cntNext;
            r_out  <= w_outNext;
            r_rise <= w_rise;
            r_fall <= w_fall;
        end
    end

    // Sticky flags: the set term is ORed in after the clear term is applied.
    // A clear that lands on the same cycle as a new event therefore cannot
    // lose that event.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_evt <= '0;
            r_irq <= 1'b0;
        end else begin
            r_evt <= w_evtSet | (r_evt & ~clr_i);
            r_irq <= |(r_evt & mask_i);
        end
    end

    assign out_o  = r_out;
    assign rise_o = r_rise;
    assign fall_o = r_fall;
    assign evt_o  = r_evt;
    assign irq_o  = r_irq;

endmodule

// File: tb/tb_debouncer_multi.sv
// ---------------------------------------------------------------------------
// tb_debouncer_multi
//
// Directed bench. It uses three instances, each with its own active-low reset:
//   A: NCH=4, FACTOR_POW=3, TICK_DIV=1, INIT=0, EDGE_MODE=2 (both edges)
//   B: NCH=4, FACTOR_POW=3, TICK_DIV=1, INIT=1, EDGE_MODE=0 (rise only)
//   C: NCH=2, FACTOR_POW=2, TICK_DIV=4, INIT=0, EDGE_MODE=2
//
// With FACTOR_POW=3 and a tick every clock, a steady input change shows on
// out_o at the 10th rising edge after it is driven. The count is:
//   2 synchroniser edges + 7 counts + 1 commit edge.
// Outputs are sampled 1ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_debouncer_multi;

    logic       clk;
    logic       rstA, rstB, rstC;
    logic [3:0] inA, outA, riseA, fallA, evtA, clrA, maskA;
    logic       irqA;
    logic [3:0] inB, outB, riseB, fallB, evtB, clrB, maskB;
    logic       irqB;
    logic [1:0] inC, outC, riseC, fallC, evtC, clrC, maskC;
    logic       irqC;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic sawRise;
    logic sawHigh;

    debouncer_multi #(.NCH(4), .FACTOR_POW(3), .TICK_DIV(1), .INIT(1'b0), .EDGE_MODE(2)) dutA (
        .clk_i(clk), .rst_i(rstA), .in_i(inA), .out_o(outA), .rise_o(riseA), .fall_o(fallA),
        .evt_o(evtA), .clr_i(clrA), .mask_i(maskA), .irq_o(irqA)
    );

    debouncer_multi #(.NCH(4), .FACTOR_POW(3), .TICK_DIV(1), .INIT(1'b1), .EDGE_MODE(0)) dutB (
        .clk_i(clk), .rst_i(rstB), .in_i(inB), .out_o(outB), .rise_o(riseB), .fall_o(fallB),
        .evt_o(evtB), .clr_i(clrB), .mask_i(maskB), .irq_o(irqB)
    );

    debouncer_multi #(.NCH(2), .FACTOR_POW(2), .TICK_DIV(4), .INIT(1'b0), .EDGE_MODE(2)) dutC (
        .clk_i(clk), .rst_i(rstC), .in_i(inC), .out_o(outC), .rise_o(riseC), .fall_o(fallC),
        .evt_o(evtC), .clr_i(clrC), .mask_i(maskC), .irq_o(irqC)
    );

    // 10ns clock. Rising edges fall at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Advance n rising edges, then settle 1ns past the last edge.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Safety net in case the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence: reset, latency, edges/events, collision, glitch,
    // prescaler and mid-operation reset.
    initial begin
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        inA = 4'hF; inB = 4'hF; inC = 2'b01;
        clrA = '0; maskA = '0; clrB = '0; maskB = '0; clrC = '0; maskC = '0;

        // Inputs are high while reset is held; the reset values must still win.
        waitCycles(2);
        checkOutput("rstA_out", outA, 4'h0);
        checkOutput("rstA_pulses", {riseA, fallA}, 8'h00);
        checkOutput("rstA_evt", evtA, 4'h0);
        checkOutput("rstA_irq", irqA, 1'b0);
        checkOutput("rstB_out", outB, 4'hF);
        checkOutput("rstB_evt", evtB, 4'h0);

        @(negedge clk);
        rstA = 1'b1; rstB = 1'b1;
        waitCycles(9);
        checkOutput("latA_edge9", outA, 4'h0);
        waitCycles(1);
        checkOutput("latA_edge10", outA, 4'hF);
        checkOutput("latA_rise", riseA, 4'hF);
        checkOutput("latA_evt", evtA, 4'hF);
        checkOutput("initB_nofall", fallB, 4'h0);
        checkOutput("initB_out", outB, 4'hF);
        waitCycles(1);
        checkOutput("latA_riseOneCycle", riseA, 4'h0);
        clrA = 4'hF;
        waitCycles(1);
        clrA = 4'h0;
        checkOutput("clrA_all", evtA, 4'h0);

        // Channel 1 falls, then rises. The interrupt is enabled on channel 1.
        inA = 4'b1101;
        waitCycles(9);
        checkOutput("fall1_early", outA, 4'hF);
        waitCycles(1);
        checkOutput("fall1_out", outA, 4'hD);
        checkOutput("fall1_pulse", {riseA, fallA}, 8'h02);
        checkOutput("fall1_evt", evtA, 4'h2);
        maskA = 4'h2;
        waitCycles(1);
        checkOutput("fall1_irq", irqA, 1'b1);
        checkOutput("fall1_pulseEnd", fallA, 4'h0);
        clrA = 4'h2;
        waitCycles(1);
        clrA = 4'h0;
        checkOutput("clr1_evt", evtA, 4'h0);
        checkOutput("clr1_irqLag", irqA, 1'b1);
        waitCycles(1);
        checkOutput("clr1_irqDrop", irqA, 1'b0);
        inA = 4'hF;
        waitCycles(10);
        checkOutput("rise1_pulse", {riseA, fallA}, 8'h20);
        checkOutput("rise1_evt", evtA, 4'h2);
        checkOutput("rise1_irqLag", irqA, 1'b0);
        waitCycles(1);
        checkOutput("rise1_irq", irqA, 1'b1);

        // Channel 2: the clear is held through the cycle of a new rise; the set must win.
        inA = 4'b1011;
        waitCycles(10);
        checkOutput("fall2_evt", evtA, 4'h6);
        clrA = 4'h4;
        waitCycles(1);
        checkOutput("clr2_evt", evtA, 4'h2);
        inA = 4'hF;
        waitCycles(10);
        clrA = 4'h0;
        checkOutput("coll2_rise", riseA, 4'h4);
        checkOutput("coll2_evt", evtA, 4'h6);
        waitCycles(1);
        checkOutput("coll2_hold", evtA, 4'h6);
        clrA = 4'h4;
        waitCycles(1);
        clrA = 4'h0;
        checkOutput("coll2_clear", evtA, 4'h2);
        checkOutput("mask_irqOn", irqA, 1'b1);
        maskA = 4'h0;
        waitCycles(1);
        checkOutput("mask_irqOff", irqA, 1'b0);

        // Instance B (rise-only events): a fall must pulse but leave no flag.
        inB = 4'b1110;
        waitCycles(10);
        checkOutput("fallB_pulse", fallB, 4'h1);
        checkOutput("fallB_out", outB, 4'hE);
        checkOutput("fallB_noEvt", evtB, 4'h0);

        // Glitch rejection: a 1-cycle high pulse every 3 cycles, for 40 cycles.
        sawRise = 1'b0;
        sawHigh = 1'b0;
        for (int i = 0; i < 40; i++) begin
            inB[0] = (i % 3 == 0);
            waitCycles(1);
            sawRise = sawRise | riseB[0];
            sawHigh = sawHigh | outB[0];
        end
        inB[0] = 1'b0;
        waitCycles(5);
        checkOutput("glitch_noRise", sawRise, 1'b0);
        checkOutput("glitch_outLow", sawHigh, 1'b0);
        inB = 4'hF;
        waitCycles(10);
        checkOutput("riseB_pulse", riseB, 4'h1);
        checkOutput("riseB_evt", evtB, 4'h1);

        // Instance C: the prescaler is in phase 0 at release.
        // Ticks fall on edges 4, 8, 12 and 16.
        @(negedge clk);
        rstC = 1'b1;
        waitCycles(15);
        checkOutput("presc_ch0_edge15", outC, 2'b00);
        waitCycles(1);
        checkOutput("presc_ch0_edge16", outC, 2'b01);
        checkOutput("presc_ch0_rise", riseC, 2'b01);
        // Driven after edge 18: s1 updates at edge 20, so that tick is missed.
        // Counting starts at tick 24, and out rises at edge 36.
        waitCycles(2);
        inC = 2'b11;
        waitCycles(17);
        checkOutput("presc_ch1_edge35", outC, 2'b01);
        waitCycles(1);
        checkOutput("presc_ch1_edge36", outC, 2'b11);
        checkOutput("presc_ch1_rise", riseC, 2'b10);

        // Mid-count async reset on A.
        // Channel 3 is driven to cnt=5 while flag 1 is set and masked.
        maskA = 4'h2;
        inA = 4'b0111;
        waitCycles(4);
        checkOutput("midrst_preIrq", irqA, 1'b1);
        checkOutput("midrst_preOut", outA, 4'hF);
        #2;
        rstA = 1'b0;
        #1;
        checkOutput("midrst_out", outA, 4'h0);
        checkOutput("midrst_evt", evtA, 4'h0);
        checkOutput("midrst_irq", irqA, 1'b0);
        checkOutput("midrst_pulses", {riseA, fallA}, 8'h00);
        inA = 4'b1000;
        @(negedge clk);
        rstA = 1'b1;
        waitCycles(9);
        checkOutput("midrst_fullCount9", outA, 4'h0);
        waitCycles(1);
        checkOutput("midrst_fullCount10", outA, 4'h8);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
